// File: rtl/y_booth_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : y_booth_mul_pkg
// Purpose  : Shared constants and Booth recode helper for y_booth_mul.
// Revision : 1.0 - initial release
// ============================================================================
package y_booth_mul_pkg;

   localparam int c_DEF_W = 32;

   localparam logic [1:0] c_ST_IDLE = 2'b00;
   localparam logic [1:0] c_ST_RUN  = 2'b01;
   localparam logic [1:0] c_ST_DONE = 2'b10;

   localparam logic [1:0] c_BOOTH_NOP = 2'b00;
   localparam logic [1:0] c_BOOTH_ADD = 2'b01;
   localparam logic [1:0] c_BOOTH_SUB = 2'b10;

   // Radix-2 recode of the {Q[0], q_1} bit pair.
   function automatic logic [1:0] booth_recode(input logic q0, input logic q1);
      case ({q0, q1})
         2'b01:   return c_BOOTH_ADD;
         2'b10:   return c_BOOTH_SUB;
         default: return c_BOOTH_NOP;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/booth_addsub.sv
`default_nettype none
// ============================================================================
// Module   : booth_addsub
// Purpose  : Combinational N-bit adder/subtractor, ctrl=1 computes x - y.
// Revision : 1.0 - initial release
// ============================================================================
module booth_addsub #(
   parameter int N = 33
) (
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
   input  logic         ctrl,
   output logic [N-1:0] z,
   output logic         cout
);

   logic [N-1:0] w_y_inv;
   logic [N:0]   w_sum;

   // Two's-complement subtract: invert y and inject ctrl as carry-in.
   assign w_y_inv = y ^ {N{ctrl}};
   assign w_sum   = {1'b0, x} + {1'b0, w_y_inv} + {{N{1'b0}}, ctrl};
   assign z       = w_sum[N-1:0];
   assign cout    = w_sum[N];

endmodule
`default_nettype wire

// File: rtl/y_booth_mul.sv
`default_nettype none
// ============================================================================
// Module   : y_booth_mul
// Purpose  : Sequential signed WxW radix-2 Booth multiplier, one step/clock.
// Revision : 1.0 - initial release
// ============================================================================
module y_booth_mul
   import y_booth_mul_pkg::*;
#(
   parameter int W = c_DEF_W
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] product
);

   localparam int            CW          = $clog2(W + 1);
   localparam logic [CW-1:0] c_CNT_LOAD  = CW'(W);
   localparam logic [CW-1:0] c_CNT_LAST  = CW'(1);

   logic [1:0]     r_state;
   logic [W:0]     r_m;
   logic [W:0]     r_a;
   logic [W-1:0]   r_q;
   logic           r_q1;
   logic [CW-1:0]  r_cnt;
   logic [2*W-1:0] r_product;

   logic [1:0]     w_op;
   logic [W:0]     w_sum;
   logic           w_unused_cout;
   logic [W:0]     w_a_new;
   logic [W:0]     w_a_sh;
   logic [W-1:0]   w_q_sh;
   logic           w_q1_sh;
   logic           w_load;

   assign w_op = booth_recode(r_q[0], r_q1);

   booth_addsub #(
      .N (W + 1)
   ) u_addsub (
      .x    (r_a),
      .y    (r_m),
      .ctrl (w_op == c_BOOTH_SUB),
      .z    (w_sum),
      .cout (w_unused_cout)
   );

   assign w_a_new = (w_op == c_BOOTH_NOP) ? r_a : w_sum;

   // Arithmetic right shift of {A', Q, q_1}; A' sign bit replicates.
   assign w_a_sh  = {w_a_new[W], w_a_new[W:1]};
   assign w_q_sh  = {w_a_new[0], r_q[W-1:1]};
   assign w_q1_sh = r_q[0];

   assign w_load = start && (r_state != c_ST_RUN);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= c_ST_IDLE;
         r_m       <= '0;
         r_a       <= '0;
         r_q       <= '0;
         r_q1      <= 1'b0;
         r_cnt     <= '0;
         r_product <= '0;
      end else begin
         case (r_state)
            c_ST_IDLE, c_ST_DONE: begin
               if (w_load) begin
                  r_m     <= {a[W-1], a};
                  r_a     <= '0;
                  r_q     <= b;
                  r_q1    <= 1'b0;
                  r_cnt   <= c_CNT_LOAD;
                  r_state <= c_ST_RUN;
               end else begin
                  r_state <= c_ST_IDLE;
               end
            end
            c_ST_RUN: begin
               r_a   <= w_a_sh;
               r_q   <= w_q_sh;
               r_q1  <= w_q1_sh;
               r_cnt <= r_cnt - c_CNT_LAST;
               // Product is captured only on the final iteration.
               if (r_cnt == c_CNT_LAST) begin
                  r_product <= {w_a_sh[W-1:0], w_q_sh};
                  r_state   <= c_ST_DONE;
               end
            end
            default: r_state <= c_ST_IDLE;
         endcase
      end
   end

   assign busy    = (r_state == c_ST_RUN);
   assign done    = (r_state == c_ST_DONE);
   assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_y_booth_mul.sv
`default_nettype none
// ============================================================================
// Module   : tb_y_booth_mul
// Purpose  : Directed and back-to-back checks of y_booth_mul (W=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_y_booth_mul;

   localparam int W = 32;
   localparam int N_B2B = 1000;

   logic           clk;
   logic           reset;
   logic           start;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           busy;
   logic           done;
   logic [2*W-1:0] product;

   int n_chk;
   int n_err;

   y_booth_mul #(
      .W (W)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] smul(input logic [31:0] x, input logic [31:0] y);
      logic signed [63:0] sx;
      logic signed [63:0] sy;
      sx = $signed({{32{x[31]}}, x});
      sy = $signed({{32{y[31]}}, y});
      return sx * sy;
   endfunction

   // Single operation: latency, busy length, product and one-cycle done.
   task automatic do_mul(input string tag, input logic [31:0] ta, input logic [31:0] tb_, input logic [63:0] exp);
      int lat;
      int nbusy;
      @(negedge clk);
      a = ta; b = tb_; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat   = 0;
      nbusy = busy ? 1 : 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = i;
            break;
         end
         if (busy) nbusy++;
      end
      chk({tag, "_lat"}, 64'(lat), 64'(W));
      chk({tag, "_busy"}, 64'(nbusy), 64'(W));
      chk({tag, "_prod"}, product, exp);
      @(posedge clk); #1;
      chk({tag, "_pulse"}, {63'd0, done}, 64'd0);
   endtask

   logic [31:0] ra [N_B2B+1];
   logic [31:0] rb [N_B2B+1];

   initial begin
      int ndone;
      int lat;
      n_chk = 0;
      n_err = 0;
      reset = 1'b1; start = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_prod", product, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      do_mul("pos",   32'd3,          32'd5,          64'h0000_0000_0000_000F);
      do_mul("mix",   32'hFFFF_FFF9,  32'd6,          64'hFFFF_FFFF_FFFF_FFD6);
      do_mul("zero",  32'd0,          32'h7FFF_FFFF,  64'h0000_0000_0000_0000);
      do_mul("min2",  32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000);
      do_mul("minm1", 32'h8000_0000,  32'hFFFF_FFFF,  64'h0000_0000_8000_0000);
      do_mul("m1m1",  32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h0000_0000_0000_0001);

      // Start during RUN is ignored; operands may change mid-run.
      @(negedge clk);
      a = 32'd2; b = 32'd9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      start = 1'b1; a = 32'd100; b = 32'd100;
      @(negedge clk);
      start = 1'b0; a = 32'h1234_5678; b = 32'hDEAD_BEEF;
      ndone = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      chk("prot_ndone", 64'(ndone), 64'd1);
      chk("prot_prod", product, 64'd18);
      chk("prot_idle", {63'd0, busy}, 64'd0);

      // Asynchronous reset mid-run.
      @(negedge clk);
      a = 32'd3; b = 32'd5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (14) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      chk("arst_busy", {63'd0, busy}, 64'd0);
      chk("arst_done", {63'd0, done}, 64'd0);
      chk("arst_prod", product, 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      chk("arst_nodone", 64'(ndone), 64'd0);
      do_mul("post", 32'd12, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFDC);

      // Back-to-back with start held high across DONE.
      ra[0] = 32'h8000_0000; rb[0] = 32'h8000_0000;
      ra[1] = 32'h7FFF_FFFF; rb[1] = 32'h8000_0000;
      ra[2] = 32'hFFFF_FFFF; rb[2] = 32'h7FFF_FFFF;
      for (int k = 3; k <= N_B2B; k++) begin
         ra[k] = $urandom;
         rb[k] = $urandom;
      end
      @(negedge clk);
      a = ra[0]; b = rb[0]; start = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < N_B2B; k++) begin
         @(negedge clk);
         a = ra[k+1]; b = rb[k+1];
         lat = 0;
         for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
               lat = i;
               break;
            end
         end
         chk("b2b_lat", 64'(lat), 64'(W));
         chk("b2b_prod", product, smul(ra[k], rb[k]));
         if (lat == 0) break;
         @(posedge clk); #1;
      end
      start = 1'b0;
      repeat (40) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/y_booth_mul.md
# y_booth_mul

Sequential signed W×W multiplier using radix-2 Booth recoding. One add/subtract plus one arithmetic right shift per clock; full 2W-bit product after W iterations. It consumes an add/subtract datapath with the same interface and semantics as the team's adder/subtractor (ctrl=0 add, ctrl=1 subtract). It sits beside the ALU in the execute stage as the multi-cycle multiply unit, with a start/done handshake toward the control unit.

## Interface
- W, default 32, operand width in bits, W ≥ 4.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- a  input  W  signed multiplicand, captured on accepted start.
- b  input  W  signed multiplier, captured on accepted start.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse; product valid.
- product  output  2W  signed a*b; held until the next accepted start.

## Operation
- States: IDLE, RUN, DONE.
- Registers:
  - M: W+1 bits, sign-extended a.
  - A: W+1 bits, accumulator.
  - Q: W bits, multiplier/low product.
  - q_1: 1 bit.
  - cnt: ceil(log2(W+1)) bits.
- Accepted start, in IDLE or DONE:
  - M ← sext(a), A ← 0, Q ← b, q_1 ← 0, cnt ← W, next state RUN.
- RUN, each cycle, on {Q[0], q_1}:
  - 01: A ← A + M.
  - 10: A ← A − M.
  - 00 / 11: A unchanged.
  - Then arithmetic shift right of {A', Q, q_1} by 1; A' sign bit replicates.
  - cnt ← cnt − 1.
  - When cnt reaches 1 in RUN, next state is DONE.
- Arithmetic rules:
  - The add/sub is W+1 bits wide, so M = −2^(W−1) never overflows.
  - Carry-out is ignored.
- DONE:
  - done=1 for exactly one cycle.
  - Next state RUN if start=1, else IDLE.
- Output mapping: product = {A[W−1:0], Q}, registered from state. It updates only when entering DONE.
- start while busy=1 is ignored; a and b may change freely during RUN.
- Reset, asynchronous and effective at any time including mid-RUN:
  - state=IDLE, busy=0, done=0, product=0.
  - All internal registers cleared.
  - No done pulse for the aborted operation.

## Timing
- Edge 0: start accepted.
- Edges 1..W: one iteration each.
- busy=1 from after edge 0 until after edge W; W cycles high.
- done=1 and product valid in the cycle after edge W, i.e. W+1 cycles after start is sampled.
- Back-to-back: start held high in the DONE cycle re-enters RUN with no idle gap. Throughput is one result per W+1 cycles.
- Outputs are registered, with no combinational path from inputs to outputs.
- Reset values: busy=0, done=0, product=0.

## Structure
- Shared package:
  - state encoding constants (IDLE=2'b00, RUN=2'b01, DONE=2'b10).
  - Booth recode constants (ADD, SUB, NOP).
  - Default width constant 32.
- Sub-module booth_addsub:
  - (W+1)-bit combinational add/sub.
  - Ports: z, cout, x, y, ctrl; ctrl=1 subtracts.
  - Same semantics as the existing adder/subtractor, so it can be swapped for it.
- The top level holds the FSM, counter and shift registers.

## Test plan
- Small positives: a=3, b=5, start 1 cycle → busy high 32 cycles, done pulse at cycle 33, product=15.
- Mixed signs: a=−7, b=6 → product=−42 (0xFFFF_FFFF_FFFF_FFD6); also a=0, b=0x7FFF_FFFF → product=0.
- Extremes:
  - a=b=0x8000_0000 → product=0x4000_0000_0000_0000.
  - a=0x8000_0000, b=−1 → product=0x0000_0000_8000_0000.
- Busy protection: start a=2, b=9, then pulse start with a=100, b=100 at cycle 10 and change a and b mid-run → product=18, a single done pulse.
- Reset mid-run: assert reset asynchronously at cycle 15 of a run → busy, done and product are 0 immediately, with no done pulse. A new start after reset gives the correct result.
- Back-to-back and random:
  - start held high across DONE, 1000 random signed pairs.
  - Required: each done is W+1 cycles after acceptance, and product equals the 64-bit signed a*b.
